// File: rtl/gcd_job_ctrl_if.sv
// Request/response handshake bundle between a job initiator and gcd_job_ctrl.
// The master side issues operand pairs and consumes results; the slave side is the controller.
interface gcd_job_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_gcd;
   logic             rsp_err;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_gcd, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_gcd, rsp_err
   );
endinterface

// File: rtl/gcd_job_ctrl.sv
// Initiator-side job controller for the gcd core: accepts operand pairs, sequences the
// core through load/run, short-circuits zero operands and aborts jobs that never finish.
module gcd_job_ctrl #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned TIMEOUT_W = 16,
   parameter int unsigned TIMEOUT   = 60000
) (
   input  logic             clk,
   input  logic             reset,
   gcd_job_ctrl_if.slave    bus,
   output logic             busy,
   output logic [WIDTH-1:0] gcd_in1,
   output logic [WIDTH-1:0] gcd_in2,
   output logic             gcd_reset,
   input  logic [WIDTH-1:0] gcd_out,
   input  logic             gcd_done
);

   localparam logic [TIMEOUT_W-1:0] RUN_LAST = TIMEOUT_W'(TIMEOUT - 1);

   // Elaboration-time guard on the timeout range.
   if (TIMEOUT < 1 || TIMEOUT >= (64'd1 << TIMEOUT_W)) begin : g_bad_timeout
      $error("gcd_job_ctrl: TIMEOUT out of range for TIMEOUT_W");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t               state;
   logic [TIMEOUT_W-1:0] run_cnt;

   logic a_zero;
   logic b_zero;

   assign a_zero = (bus.req_a == '0);
   assign b_zero = (bus.req_b == '0);

   // Job sequencer; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         run_cnt       <= '0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_gcd   <= '0;
         bus.rsp_err   <= 1'b0;
         busy          <= 1'b0;
         gcd_in1       <= '0;
         gcd_in2       <= '0;
         gcd_reset     <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  gcd_in1       <= bus.req_a;
                  gcd_in2       <= bus.req_b;
                  bus.req_ready <= 1'b0;
                  busy          <= 1'b1;
                  // A zero operand never reaches the core: gcd(x,0)=x, gcd(0,0) is an error.
                  if (a_zero || b_zero) begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_gcd   <= bus.req_a | bus.req_b;
                     bus.rsp_err   <= a_zero && b_zero;
                     state         <= RESP;
                  end else begin
                     state <= LOAD;
                  end
               end
            end

            LOAD: begin
               run_cnt   <= '0;
               gcd_reset <= 1'b0;
               state     <= RUN;
            end

            RUN: begin
               run_cnt <= run_cnt + TIMEOUT_W'(1);
               if (gcd_done) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_gcd   <= gcd_out;
                  bus.rsp_err   <= 1'b0;
                  gcd_reset     <= 1'b1;
                  state         <= RESP;
               end else if (run_cnt == RUN_LAST) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_gcd   <= '0;
                  bus.rsp_err   <= 1'b1;
                  gcd_reset     <= 1'b1;
                  state         <= RESP;
               end
            end

            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_job_ctrl.sv
// Self-checking bench for gcd_job_ctrl with a behavioural subtractive gcd core attached.
module tb_gcd_job_ctrl;
   localparam int unsigned WIDTH     = 32;
   localparam int unsigned TIMEOUT_W = 16;
   localparam int unsigned TIMEOUT   = 100;

   logic             clk = 1'b0;
   logic             reset;
   logic             busy;
   logic [WIDTH-1:0] gcd_in1;
   logic [WIDTH-1:0] gcd_in2;
   logic             gcd_reset;
   logic [WIDTH-1:0] gcd_out;
   logic             gcd_done;

   gcd_job_ctrl_if #(.WIDTH(WIDTH)) bus ();

   gcd_job_ctrl #(
      .WIDTH     (WIDTH),
      .TIMEOUT_W (TIMEOUT_W),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .busy      (busy),
      .gcd_in1   (gcd_in1),
      .gcd_in2   (gcd_in2),
      .gcd_reset (gcd_reset),
      .gcd_out   (gcd_out),
      .gcd_done  (gcd_done)
   );

   always #5 clk = ~clk;

   // Subtractive gcd core: loads while held in reset, raises done once x==y and holds it.
   logic [WIDTH-1:0] cx, cy;
   logic             cdone;
   bit               hang  = 1'b0;
   bit               stale = 1'b0;

   always @(posedge clk) begin
      if (gcd_reset) begin
         cx    <= gcd_in1;
         cy    <= gcd_in2;
         cdone <= 1'b0;
      end else if (!cdone) begin
         if (cx == cy)     cdone <= 1'b1;
         else if (cx > cy) cx    <= cx - cy;
         else              cy    <= cy - cx;
      end
   end

   assign gcd_out  = cx;
   assign gcd_done = hang ? 1'b0 : (cdone | (stale & gcd_reset));

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int sub_steps(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      int n = 0;
      while (x != y) begin
         if (x > y) x = x - y;
         else       y = y - x;
         n++;
      end
      return n;
   endfunction

   task automatic wait_ready();
      int k = 0;
      while (!bus.req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("req_ready_wait", bus.req_ready, 1);
   endtask

   // One job end-to-end; expectations come from the arithmetic model, not the DUT.
   task automatic run_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int hold, input bit early_ready);
      logic [WIDTH-1:0] eg;
      logic             ee;
      int               er, lat, run;
      bit               zero_path;
      zero_path = (a == 0) || (b == 0);
      if (a == 0 && b == 0) begin eg = 0; ee = 1; er = 0; end
      else if (zero_path)   begin eg = a | b; ee = 0; er = 0; end
      else if (hang)        begin eg = 0; ee = 1; er = TIMEOUT; end
      else                  begin eg = ref_gcd(a, b); ee = 0; er = sub_steps(a, b) + 2; end

      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.rsp_ready = early_ready;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_a     = $urandom;
      bus.req_b     = $urandom;
      check("gcd_in1_latch", gcd_in1, a);
      check("gcd_in2_latch", gcd_in2, b);
      check("busy_after_accept", busy, 1);
      check("req_ready_after_accept", bus.req_ready, 0);
      if (!zero_path) check("load_holds_core_reset", gcd_reset, 1);

      lat = 1;
      run = 0;
      while (!bus.rsp_valid && lat < 400) begin
         if (!gcd_reset) run++;
         @(negedge clk);
         lat++;
      end
      check("rsp_valid_seen", bus.rsp_valid, 1);
      check("rsp_gcd", bus.rsp_gcd, eg);
      check("rsp_err", bus.rsp_err, ee);
      check("run_cycles", run, er);
      check("core_reset_in_resp", gcd_reset, 1);
      if (zero_path) check("zero_path_latency", lat, 1);

      if (!early_ready) begin
         for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_a     = a + 1;
            bus.req_b     = b + 3;
            @(negedge clk);
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_gcd", bus.rsp_gcd, eg);
            check("hold_req_ready", bus.req_ready, 0);
            check("hold_gcd_in1", gcd_in1, a);
         end
         bus.req_valid = 1'b0;
         bus.rsp_ready = 1'b1;
      end
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("rsp_valid_drop", bus.rsp_valid, 0);
      check("req_ready_back", bus.req_ready, 1);
      check("busy_clear", busy, 0);
   endtask

   initial begin
      int k;
      logic [WIDTH-1:0] ra, rb;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_gcd", bus.rsp_gcd, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_busy", busy, 0);
      check("rst_gcd_in1", gcd_in1, 0);
      check("rst_gcd_in2", gcd_in2, 0);
      check("rst_gcd_reset", gcd_reset, 1);
      reset = 1'b0;
      @(negedge clk);

      run_job(64, 212, 0, 1'b1);
      run_job(0, 18, 0, 1'b0);
      run_job(0, 0, 1, 1'b0);
      run_job(25, 0, 0, 1'b1);

      hang = 1'b1;
      run_job(7, 9, 0, 1'b0);
      hang = 1'b0;

      run_job(48, 36, 5, 1'b0);
      run_job(13, 13, 0, 1'b1);

      // Reset dropped into the middle of a long job.
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_a     = 1000;
      bus.req_b     = 7;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      k = 0;
      while (gcd_reset && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("mid_job_running", gcd_reset, 0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_gcd_reset", gcd_reset, 1);
      check("mid_rst_rsp_valid", bus.rsp_valid, 0);
      check("mid_rst_req_ready", bus.req_ready, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_gcd_in1", gcd_in1, 0);
      run_job(9, 6, 0, 1'b0);

      // Random jobs, some with a stale done level shown while the core is in reset.
      for (int i = 0; i < 12; i++) begin
         ra    = $urandom_range(0, 40);
         rb    = $urandom_range(0, 40);
         stale = 1'($urandom_range(0, 1));
         run_job(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      stale = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
